// File: rtl/nand_id_responder.sv
// nand_id_responder: device-side NAND responder for READ ID, READ STATUS and RESET
module nand_id_responder #(
  parameter logic [39:0] ID_VALUE = 40'h58_95_51_D3_EC,
  parameter int ID_BYTES = 5,
  parameter int RST_BUSY_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_n,
  input  logic       cle,
  input  logic       ale,
  input  logic       we_n,
  input  logic       re_n,
  input  logic [7:0] io_in,
  output logic [7:0] io_out,
  output logic       io_oe,
  output logic       rb_n,
  output logic [2:0] state_tb
);
  typedef enum logic [2:0] {IDLE = 3'd0, ID_ADDR = 3'd1, ID_OUT = 3'd2, STAT_OUT = 3'd3} state_t;
  typedef enum logic [1:0] {SRC_ID, SRC_ONFI, SRC_ZERO} src_t;
  localparam int CW = $clog2(RST_BUSY_CYC + 1);
  localparam logic [63:0] ID_WORD = {24'h0, ID_VALUE};
  localparam logic [31:0] ONFI_SIG = 32'h49_46_4E_4F;
  state_t state;
  src_t src;
  logic we_q, re_q, wr_ev, rf_ev, rr_ev;
  logic [2:0] ptr, ptr_last;
  logic [7:0] rd_byte;
  logic [CW-1:0] busy_cnt;
  assign wr_ev = !ce_n && we_n && !we_q;
  assign rf_ev = !ce_n && !re_n && re_q;
  assign rr_ev = re_n && !re_q;
  assign rb_n = busy_cnt == '0;
  assign state_tb = state;
  assign ptr_last = src == SRC_ID ? 3'(ID_BYTES - 1) : 3'd3;
  assign rd_byte = src == SRC_ID ? ID_WORD[{ptr, 3'b000} +: 8] :
                   src == SRC_ONFI ? ONFI_SIG[{ptr[1:0], 3'b000} +: 8] : 8'h00;
  // Write events outrank reads, so an illegal overlap leaves io_oe low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      src <= SRC_ID;
      we_q <= 1'b1;
      re_q <= 1'b1;
      ptr <= '0;
      busy_cnt <= '0;
      io_out <= 8'h00;
      io_oe <= 1'b0;
    end else begin
      we_q <= we_n;
      re_q <= re_n;
      if (busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
      if (ce_n) begin
        state <= IDLE;
        io_oe <= 1'b0;
      end else if (wr_ev) begin
        io_oe <= 1'b0;
        if (cle && !ale) begin
          if (io_in == 8'hFF) begin
            busy_cnt <= CW'(RST_BUSY_CYC);
            state <= IDLE;
          end else if (io_in == 8'h70) state <= STAT_OUT;
          else if (io_in == 8'h90) begin
            if (rb_n) state <= ID_ADDR;
          end else state <= IDLE;
        end else if (ale && !cle && state == ID_ADDR) begin
          src <= io_in == 8'h00 ? SRC_ID : io_in == 8'h20 ? SRC_ONFI : SRC_ZERO;
          ptr <= '0;
          state <= ID_OUT;
        end
      end else if (rf_ev && (state == ID_OUT || state == STAT_OUT)) begin
        io_out <= state == ID_OUT ? rd_byte : rb_n ? 8'hE0 : 8'h80;
        io_oe <= 1'b1;
      end else if (rr_ev) begin
        io_oe <= 1'b0;
        if (state == ID_OUT) ptr <= ptr == ptr_last ? '0 : ptr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_nand_id_responder.sv
// tb_nand_id_responder: vector table, directed corner cases and random ops against a byte-list model
module tb_nand_id_responder;
  localparam logic [39:0] ID = 40'h58_95_51_D3_EC;
  localparam logic [31:0] ONFI_STR = "ONFI";
  localparam int BUSY = 16;
  logic clk = 0, reset = 0, ce_n = 1, cle = 0, ale = 0, we_n = 1, re_n = 1;
  logic [7:0] io_in = 0, io_out;
  logic io_oe, rb_n;
  logic [2:0] state_tb;
  int errors = 0, checks = 0, pcount = 0, ff_pos = -1000, run = 0, last_run = 0;
  int m_mode = 0, m_idx = 0;
  logic [7:0] m_bytes[$];
  typedef struct {bit rd; logic c; logic a; logic [7:0] d; logic [2:0] st; logic [7:0] q; bit oe;} vec_t;
  vec_t tbl[$];

  nand_id_responder dut (.clk(clk), .reset(reset), .ce_n(ce_n), .cle(cle), .ale(ale), .we_n(we_n),
    .re_n(re_n), .io_in(io_in), .io_out(io_out), .io_oe(io_oe), .rb_n(rb_n), .state_tb(state_tb));

  always #5 clk = ~clk;
  always @(posedge clk) pcount++;
  always @(negedge clk)
    if (!rb_n) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic bit m_busy(input int n);
    return n - ff_pos < BUSY;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_cyc(input logic c, input logic a, input logic [7:0] d);
    we_n = 0; cle = c; ale = a; io_in = d;
    @(negedge clk);
    we_n = 1;
    @(negedge clk);
    cle = 0; ale = 0;
    if (c && !a) begin
      if (d == 8'hFF) begin
        ff_pos = pcount;
        m_mode = 0;
      end else if (d == 8'h70) m_mode = 3;
      else if (d == 8'h90) begin
        if (!m_busy(pcount - 1)) m_mode = 1;
      end else m_mode = 0;
    end else if (a && !c && m_mode == 1) begin
      m_bytes.delete();
      m_idx = 0;
      m_mode = 2;
      for (int i = 0; i < (d == 8'h00 ? 5 : 4); i++)
        m_bytes.push_back(d == 8'h00 ? ID[8*i +: 8] : d == 8'h20 ? ONFI_STR[31-8*i -: 8] : 8'h00);
    end
  endtask

  task automatic read_pulse(output logic [7:0] q, output logic on, output logic off, output logic pre,
                            output logic [7:0] mq, output logic moe);
    pre = io_oe;
    re_n = 0;
    repeat (2) @(negedge clk);
    q = io_out;
    on = io_oe;
    moe = m_mode == 2 || m_mode == 3;
    mq = 8'h00;
    if (m_mode == 2) begin
      mq = m_bytes[m_idx];
      m_idx = (m_idx + 1) % m_bytes.size();
    end else if (m_mode == 3) mq = m_busy(pcount - 2) ? 8'h80 : 8'hE0;
    @(negedge clk);
    re_n = 1;
    repeat (2) @(negedge clk);
    off = io_oe;
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    while (!rb_n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_ready"}, rb_n, 1);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] q, mq;
    logic on, off, pre, moe;
    #1 reset = 1;
    repeat (2) @(negedge clk);
    chk("rst_io_out", io_out, 8'h00);
    chk("rst_io_oe", io_oe, 0);
    chk("rst_rb_n", rb_n, 1);
    chk("rst_state", state_tb, 0);
    reset = 0;
    ce_n = 0;
    @(negedge clk);

    tbl.push_back('{0, 1, 0, 8'h90, 3'd1, 8'h00, 0});
    tbl.push_back('{0, 0, 1, 8'h00, 3'd2, 8'h00, 0});
    tbl.push_back('{1, 0, 0, 8'h00, 3'd2, 8'hEC, 1});
    tbl.push_back('{1, 0, 0, 8'h00, 3'd2, 8'hD3, 1});
    tbl.push_back('{1, 0, 0, 8'h00, 3'd2, 8'h51, 1});
    tbl.push_back('{1, 0, 0, 8'h00, 3'd2, 8'h95, 1});
    tbl.push_back('{1, 0, 0, 8'h00, 3'd2, 8'h58, 1});
    tbl.push_back('{1, 0, 0, 8'h00, 3'd2, 8'hEC, 1});
    tbl.push_back('{0, 1, 0, 8'h90, 3'd1, 8'h00, 0});
    tbl.push_back('{0, 0, 1, 8'h20, 3'd2, 8'h00, 0});
    tbl.push_back('{1, 0, 0, 8'h00, 3'd2, 8'h4F, 1});
    tbl.push_back('{1, 0, 0, 8'h00, 3'd2, 8'h4E, 1});
    tbl.push_back('{1, 0, 0, 8'h00, 3'd2, 8'h46, 1});
    tbl.push_back('{1, 0, 0, 8'h00, 3'd2, 8'h49, 1});
    tbl.push_back('{0, 1, 0, 8'h90, 3'd1, 8'h00, 0});
    tbl.push_back('{0, 0, 1, 8'h35, 3'd2, 8'h00, 0});
    tbl.push_back('{1, 0, 0, 8'h00, 3'd2, 8'h00, 1});
    tbl.push_back('{1, 0, 0, 8'h00, 3'd2, 8'h00, 1});
    tbl.push_back('{0, 1, 0, 8'h70, 3'd3, 8'h00, 0});
    tbl.push_back('{1, 0, 0, 8'h00, 3'd3, 8'hE0, 1});
    tbl.push_back('{0, 1, 1, 8'h90, 3'd3, 8'h00, 0});
    tbl.push_back('{0, 0, 0, 8'h90, 3'd3, 8'h00, 0});
    tbl.push_back('{0, 1, 0, 8'hAB, 3'd0, 8'h00, 0});
    tbl.push_back('{1, 0, 0, 8'h00, 3'd0, 8'h00, 0});
    foreach (tbl[i]) begin
      if (!tbl[i].rd) write_cyc(tbl[i].c, tbl[i].a, tbl[i].d);
      else begin
        read_pulse(q, on, off, pre, mq, moe);
        chk($sformatf("tbl%0d_oe_pre", i), pre, 0);
        chk($sformatf("tbl%0d_oe_on", i), on, tbl[i].oe);
        if (tbl[i].oe) chk($sformatf("tbl%0d_byte", i), q, tbl[i].q);
        chk($sformatf("tbl%0d_oe_off", i), off, 0);
      end
      chk($sformatf("tbl%0d_state", i), state_tb, tbl[i].st);
    end

    write_cyc(1, 0, 8'hFF);
    chk("ff_rb_low", rb_n, 0);
    wait_ready("ff1");
    chk("ff1_busy_len", last_run, 16);

    write_cyc(1, 0, 8'hFF);
    write_cyc(1, 0, 8'h90);
    chk("busy_90_state", state_tb, 0);
    write_cyc(1, 0, 8'h70);
    read_pulse(q, on, off, pre, mq, moe);
    chk("busy_stat_oe", on, 1);
    chk("busy_stat", q, 8'h80);
    wait_ready("ff2");
    chk("ff2_busy_len", last_run, 16);
    read_pulse(q, on, off, pre, mq, moe);
    chk("ready_stat", q, 8'hE0);
    chk("ready_stat_off", off, 0);

    write_cyc(1, 0, 8'hFF);
    repeat (3) @(negedge clk);
    write_cyc(1, 0, 8'hFF);
    wait_ready("reload");
    chk("reload_busy_len", last_run, 21);

    write_cyc(1, 0, 8'h90);
    write_cyc(0, 1, 8'h00);
    read_pulse(q, on, off, pre, mq, moe);
    chk("ce_b0", q, 8'hEC);
    read_pulse(q, on, off, pre, mq, moe);
    chk("ce_b1", q, 8'hD3);
    ce_n = 1;
    @(negedge clk);
    chk("ce_oe", io_oe, 0);
    chk("ce_state", state_tb, 0);
    ce_n = 0;
    m_mode = 0;
    read_pulse(q, on, off, pre, mq, moe);
    chk("ce_read_oe", on, 0);
    chk("ce_read_state", state_tb, 0);
    write_cyc(1, 1, 8'h90);
    chk("both_high_state", state_tb, 0);

    write_cyc(1, 0, 8'h90);
    write_cyc(0, 1, 8'h00);
    re_n = 0;
    repeat (2) @(negedge clk);
    chk("pre_rst_oe", io_oe, 1);
    #2 reset = 1;
    #1;
    chk("async_rst_oe", io_oe, 0);
    chk("async_rst_out", io_out, 8'h00);
    chk("async_rst_rb", rb_n, 1);
    chk("async_rst_state", state_tb, 0);
    @(negedge clk);
    reset = 0;
    re_n = 1;
    m_mode = 0;
    ff_pos = -1000;
    @(negedge clk);

    for (int n = 0; n < 250; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 1) write_cyc(1, 0, 8'h90);
      else if (op == 2) begin
        int p;
        p = $urandom_range(0, 3);
        write_cyc(0, 1, p == 0 ? 8'h00 : p == 1 ? 8'h20 : p == 2 ? 8'h35 : 8'($urandom_range(0, 255)));
      end else if (op == 3) write_cyc(1, 0, 8'h70);
      else if (op <= 6) begin
        read_pulse(q, on, off, pre, mq, moe);
        chk($sformatf("rnd%0d_oe_on", n), on, moe);
        if (moe) chk($sformatf("rnd%0d_byte", n), q, mq);
        chk($sformatf("rnd%0d_oe_off", n), off, 0);
      end else if (op == 7) begin
        ce_n = 1;
        @(negedge clk);
        ce_n = 0;
        m_mode = 0;
      end else if (op == 8) repeat ($urandom_range(1, 20)) @(negedge clk);
      else write_cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2) == 0 ? 8'hFF : 8'($urandom_range(0, 255)));
      chk($sformatf("rnd%0d_rb", n), rb_n, !m_busy(pcount));
      chk($sformatf("rnd%0d_state", n), state_tb, m_mode);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
